hash_byte_sequencer: RTL

//   Upstream control stage for the byte-wise hash operative datapath.

---
 rtl/hash_pkg.sv | 8 +
 rtl/hash_byte_sequencer.sv | 105 ++++++++++
 2 files changed

// File: rtl/hash_pkg.sv
// hash_pkg: shared constants and sequencer state encoding for the byte-wise hash datapath
package hash_pkg;
  localparam int HASH_ROUNDS = 8;
  localparam int HASH_IDX_W = 3;
  localparam int HASH_DIGEST_W = 32;
  localparam logic [31:0] HASH_H_INIT = 32'h3FA1EF23;
  typedef enum logic [2:0] {IDLE, START, LOAD, ROUND, DONE, ERR} seq_state_t;
endpackage

// File: rtl/hash_byte_sequencer.sv
// hash_byte_sequencer: frames a host byte stream into core start, byte loads and nibble rounds
// Ports: clock/rst (sync, active-high); s_data/s_valid/s_last/s_ready host stream;
//   core_B/core_start/core_validate_in/core_switch_op/core_validate_h/core_R_i drive the core;
//   core_cnt_ok/core_digest come back from it; digest/digest_valid/err report the result.
// Config: HASH_SEQ_DIGEST_REG_EN registers the digest in DONE (held until next START);
//   otherwise digest follows core_digest while digest_valid and reads H_INIT elsewhere.
module hash_byte_sequencer
  import hash_pkg::*;
#(
  parameter int ROUNDS = HASH_ROUNDS,
  parameter int IDX_W = HASH_IDX_W,
  parameter int DIGEST_W = HASH_DIGEST_W,
  parameter logic [DIGEST_W-1:0] H_INIT = HASH_H_INIT
) (
  input  logic                clock,
  input  logic                rst,
  input  logic [7:0]          s_data,
  input  logic                s_valid,
  input  logic                s_last,
  output logic                s_ready,
  output logic [7:0]          core_B,
  output logic                core_start,
  output logic                core_validate_in,
  output logic                core_switch_op,
  output logic                core_validate_h,
  output logic [IDX_W-1:0]    core_R_i,
  input  logic                core_cnt_ok,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic [DIGEST_W-1:0] digest,
  output logic                digest_valid,
  output logic                err
);
  seq_state_t state_q, state_d;
  logic [IDX_W-1:0] r_idx_q, r_idx_d;
  logic last_q, last_d, err_q, err_d;
  logic [7:0] core_b_q, core_b_d;
  // strobes are suppressed while rst is high so an abandoned message issues nothing
  logic run;
  assign run = !rst;
  assign s_ready = run && state_q == LOAD && core_cnt_ok;
  assign core_start = run && state_q == START;
  assign core_validate_in = s_ready && s_valid;
  assign core_switch_op = run && state_q == ROUND;
  assign core_validate_h = core_switch_op;
  assign core_R_i = r_idx_q;
  assign digest_valid = run && state_q == DONE;
  assign err = err_q;
  // the core latches B in the handshake cycle, so present the byte directly then
  assign core_B = core_validate_in ? s_data : core_b_q;
  always_comb begin
    state_d = state_q;
    r_idx_d = r_idx_q;
    last_d = last_q;
    err_d = err_q;
    core_b_d = core_b_q;
    case (state_q)
      IDLE: state_d = s_valid ? START : IDLE;
      START: state_d = LOAD;
      LOAD: begin
        if (s_valid && core_cnt_ok) begin
          core_b_d = s_data;
          last_d = s_last;
          r_idx_d = '0;
          state_d = ROUND;
        end else if (s_valid) begin
          err_d = 1'b1;
          state_d = ERR;
        end
      end
      ROUND: begin
        r_idx_d = (r_idx_q == IDX_W'(ROUNDS - 1)) ? '0 : r_idx_q + 1'b1;
        state_d = (r_idx_q == IDX_W'(ROUNDS - 1)) ? (last_q ? DONE : LOAD) : ROUND;
      end
      DONE: state_d = IDLE;
      ERR: state_d = ERR;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      r_idx_q <= '0;
      last_q <= 1'b0;
      err_q <= 1'b0;
      core_b_q <= '0;
    end else begin
      state_q <= state_d;
      r_idx_q <= r_idx_d;
      last_q <= last_d;
      err_q <= err_d;
      core_b_q <= core_b_d;
    end
  end
`ifdef HASH_SEQ_DIGEST_REG_EN
  logic [DIGEST_W-1:0] digest_q, digest_d;
  assign digest_d = (state_q == START) ? H_INIT : (state_q == DONE) ? core_digest : digest_q;
  always_ff @(posedge clock) begin
    if (rst) digest_q <= H_INIT;
    else digest_q <= digest_d;
  end
  assign digest = digest_valid ? core_digest : digest_q;
`else
  assign digest = digest_valid ? core_digest : H_INIT;
`endif
endmodule
